// File: rtl/iram_loader.sv
// IRAM writer: unpacks a host byte stream into 16-bit words, fills IRAM from address 0,
// then starts the CPU and waits for its run to finish. Optional checksum: IRAM_LOADER_CHECKSUM_EN.
module iram_loader #(
    parameter int W_ADDR = 8,
    parameter int W_BYTE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [W_BYTE-1:0]     s_data,
    output logic                  s_ready,
    output logic [W_ADDR-1:0]     iram_addr,
    output logic [2*W_BYTE-1:0]   iram_din,
    output logic                  iram_write,
    output logic                  cpu_start,
    input  logic                  cpu_idle,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

`ifdef IRAM_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_HDR, S_LO, S_HI, S_WR, S_START, S_WAIT0, S_WAIT1, S_DONE, S_CHK
    } state_t;
    localparam state_t S_TAIL = S_CHK;
`else
    typedef enum logic [3:0] {
        S_HDR, S_LO, S_HI, S_WR, S_START, S_WAIT0, S_WAIT1, S_DONE
    } state_t;
    localparam state_t S_TAIL = S_START;
`endif

    localparam int W_CMP = ((W_ADDR > W_BYTE) ? W_ADDR : W_BYTE) + 1;

    state_t                state_q, state_d;
    logic [W_BYTE-1:0]     n_q, n_d;
    logic [W_ADDR-1:0]     cnt_q, cnt_d;
    logic [W_BYTE-1:0]     opc_q, opc_d;
    logic [W_ADDR-1:0]     addr_q, addr_d;
    logic [2*W_BYTE-1:0]   din_q, din_d;
    logic                  accept;
    logic                  last_word;

`ifdef IRAM_LOADER_CHECKSUM_EN
    logic [W_BYTE-1:0]     csum_q, csum_d;
    logic                  err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HDR;
            n_q     <= '0;
            cnt_q   <= '0;
            opc_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            S_HDR, S_LO, S_HI: s_ready = 1'b1;
`ifdef IRAM_LOADER_CHECKSUM_EN
            S_CHK:             s_ready = 1'b1;
`endif
            default:           s_ready = 1'b0;
        endcase
    end

    assign accept    = s_valid && s_ready;
    // Compared one bit wider so N=255 never aliases with a wrapped counter.
    assign last_word = (W_CMP'(cnt_q) + W_CMP'(1)) == W_CMP'(n_q);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        opc_d      = opc_q;
        addr_d     = addr_q;
        din_d      = din_q;
        iram_write = 1'b0;
        cpu_start  = 1'b0;
        done       = 1'b0;
`ifdef IRAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    n_d     = s_data;
                    cnt_d   = '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                    state_d = (s_data == '0) ? S_TAIL : S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    opc_d   = s_data;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ s_data;
`endif
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    addr_d  = cnt_q;
                    din_d   = {s_data, opc_q};
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ s_data;
`endif
                    state_d = S_WR;
                end
            end
            S_WR: begin
                iram_write = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                state_d    = last_word ? S_TAIL : S_LO;
            end
`ifdef IRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (s_data == csum_q) begin
                        state_d = S_START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
`endif
            S_START: begin
                cpu_start = 1'b1;
                state_d   = S_WAIT0;
            end
            S_WAIT0: begin
                if (!cpu_idle) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (cpu_idle) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    assign iram_addr = addr_q;
    assign iram_din  = din_q;
    assign busy      = (state_q != S_HDR);
`ifdef IRAM_LOADER_CHECKSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
